// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: packed-BCD adder that reuses one digit adder, one digit per clock, LSD first
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_a,
   input  logic [4*DIGITS-1:0]   in_b,
   input  logic                  in_carry,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_sum,
   output logic                  out_carry,
   output logic                  out_err,
   output logic                  busy
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;
   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                c_q, c_d, cout_q, cout_d, err_q, err_d, valid_q, valid_d;
   logic                bad, gt9;
   logic [3:0]          a_dig, b_dig, dig;
   logic [4:0]          s;
   // one-digit BCD adder stage shared by every digit position
   always_comb begin
      a_dig = a_q[{idx_q, 2'b00} +: 4];
      b_dig = b_q[{idx_q, 2'b00} +: 4];
      s     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, c_q};
      gt9   = s > 5'd9;
      dig   = gt9 ? 4'(s + 5'd6) : s[3:0];
   end
   // flag any operand digit above 9 so the result can be marked meaningless
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         bad = bad | (in_a[4*i +: 4] > 4'd9) | (in_b[4*i +: 4] > 4'd9);
   end
   // sequencer next-state: accept in IDLE, one digit per cycle in ADD, wait for consumer in HOLD
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = in_a;
            b_d     = in_b;
            c_d     = in_carry;
            err_d   = bad;
            idx_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            sum_d[{idx_q, 2'b00} +: 4] = dig;
            c_d   = gt9;
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(DIGITS - 1)) begin
               cout_d  = gt9;
               valid_d = 1'b1;
               idx_d   = '0;
               state_d = HOLD;
            end
         end
         HOLD: if (out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end
   assign in_ready  = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_carry = cout_q;
   assign out_err   = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed checks of the serial BCD adder at DIGITS=4 and DIGITS=1
module tb_bcd_serial_add_ctrl;
   logic clk = 0, reset = 1;
   logic in_valid4 = 0, in_ready4, in_c4 = 0, out_valid4, out_ready4 = 0, out_carry4, out_err4, busy4;
   logic [15:0] in_a4 = 0, in_b4 = 0, out_sum4;
   logic in_valid1 = 0, in_ready1, in_c1 = 0, out_valid1, out_ready1 = 0, out_carry1, out_err1, busy1;
   logic [3:0] in_a1 = 0, in_b1 = 0, out_sum1;
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   bcd_serial_add_ctrl #(.DIGITS(4)) u4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_a(in_a4), .in_b(in_b4), .in_carry(in_c4), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_sum(out_sum4), .out_carry(out_carry4),
      .out_err(out_err4), .busy(busy4)
   );
   bcd_serial_add_ctrl #(.DIGITS(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_carry(in_c1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_sum(out_sum1), .out_carry(out_carry1),
      .out_err(out_err1), .busy(busy1)
   );
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [15:0] es, input logic ec, input logic ee, input logic keep);
      int n;
      n = 0;
      while (!in_ready4 && n < 50) begin tick(); n++; end
      chk({tag, "_rdy"}, in_ready4, 1);
      in_valid4 = 1; in_a4 = a; in_b4 = b; in_c4 = cin;
      tick();
      in_valid4 = 0; in_a4 = '1; in_b4 = '1; in_c4 = 1;
      n = 0;
      while (!out_valid4 && n < 20) begin tick(); n++; end
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_sum"}, out_sum4, es);
      chk({tag, "_cy"}, out_carry4, ec);
      chk({tag, "_err"}, out_err4, ee);
      if (!keep) begin
         out_ready4 = 1;
         tick();
         out_ready4 = 0;
         chk({tag, "_idle"}, {out_valid4, in_ready4}, 2'b01);
      end
   endtask
   initial begin
      int n;
      tick(); tick();
      reset = 0;
      chk("rst_rdy", in_ready4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_vld", out_valid4, 0);
      chk("rst_outs", {out_sum4, out_carry4, out_err4}, 0);
      op4("add1", 16'h1234, 16'h5678, 0, 16'h6912, 0, 0, 0);
      op4("ripple", 16'h9999, 16'h0001, 0, 16'h0000, 1, 0, 0);
      op4("max", 16'h9999, 16'h9999, 1, 16'h9999, 1, 0, 0);
      op4("bad", 16'h00A0, 16'h0001, 0, 16'h0101, 0, 1, 0);
      op4("after_bad", 16'h0001, 16'h0001, 0, 16'h0002, 0, 0, 0);
      op4("bp", 16'h4321, 16'h1111, 0, 16'h5432, 0, 0, 1);
      in_valid4 = 1; in_a4 = 16'h7777; in_b4 = 16'h7777;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", {out_valid4, in_ready4, busy4, out_sum4, out_carry4, out_err4},
             {1'b1, 1'b0, 1'b1, 16'h5432, 1'b0, 1'b0});
      end
      in_valid4 = 0;
      out_ready4 = 1;
      tick();
      out_ready4 = 0;
      chk("bp_release", {out_valid4, in_ready4, busy4}, 3'b010);
      op4("bp_next", 16'h0050, 16'h0050, 0, 16'h0100, 0, 0, 0);
      in_valid4 = 1; in_a4 = 16'h5555; in_b4 = 16'h5555; in_c4 = 0;
      tick();
      in_valid4 = 0;
      tick(); tick();
      chk("abort_busy", busy4, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("abort_state", {in_ready4, busy4, out_valid4, out_sum4, out_carry4}, {1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
      op4("after_abort", 16'h0005, 16'h0005, 0, 16'h0010, 0, 0, 0);
      op4("hold_abort", 16'h0002, 16'h0003, 0, 16'h0005, 0, 0, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("hold_abort_rst", {in_ready4, out_valid4, out_sum4}, {1'b1, 1'b0, 16'h0});
      for (int a = 0; a < 10; a++)
         for (int b = 0; b < 10; b++)
            for (int c = 0; c < 2; c++) begin
               in_valid1 = 1; in_a1 = 4'(a); in_b1 = 4'(b); in_c1 = 1'(c);
               tick();
               in_valid1 = 0;
               n = 0;
               while (!out_valid1 && n < 10) begin tick(); n++; end
               chk($sformatf("sweep_%0d_%0d_%0d", a, b, c), 10 * out_carry1 + out_sum1, a + b + c);
               chk("sweep_err", {n[3:0], out_err1}, {4'd1, 1'b0});
               out_ready1 = 1;
               tick();
               out_ready1 = 0;
            end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequencer that adds two multi-digit packed-BCD operands by time-sharing a single one-digit BCD adder stage.
- Processes one digit pair per clock, least significant digit first, with a registered decimal carry between digits.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Used wherever the design needs wide decimal sums without replicating per-digit adder logic.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has an operand pair available.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  4*DIGITS  operand A, packed BCD; digit i is in_a[4i+3:4i].
- in_b  input  4*DIGITS  operand B, packed BCD, same packing as in_a.
- in_carry  input  1  decimal carry-in to digit 0.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  4*DIGITS  packed-BCD sum.
- out_carry  output  1  decimal carry out of the most significant digit.
- out_err  output  1  at least one input digit was greater than 9.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ADD, HOLD.
- Reset (reset=1 at a clock edge, in any state): state=IDLE, digit index=0, carry register=0, out_sum=0, out_carry=0, out_err=0, out_valid=0, busy=0.
- Reset aborts an operation in progress with no output, including one in HOLD.
- in_ready = (state==IDLE). It is combinational from state only, never from in_valid.

IDLE:
- On in_valid&in_ready at an edge: latch in_a, in_b, and carry register<=in_carry.
- Latch out_err <= OR over all digits of (digit>9) for both operands.
- Clear index to 0 and go to ADD.

ADD:
- Each edge processes digit i = index, using the latched A digit, the latched B digit, and the carry register c.
- s = a + b + c, computed 5 bits wide.
- If s>9: digit = (s+6)[3:0] and c<=1. Otherwise: digit = s[3:0] and c<=0.
- The resulting digit is written into out_sum digit i.
- index increments each edge. At index==DIGITS-1: out_carry <= new c, out_valid <= 1, go to HOLD.
- Latency: handshake at edge k gives out_valid high after edge k+DIGITS. For DIGITS=4, that is 4 cycles.
- Invalid digits (>9) still run through the same rule; out_err flags the result as meaningless.

HOLD:
- out_sum, out_carry and out_err are stable while out_valid=1.
- On out_valid&out_ready: out_valid<=0 and go to IDLE.
- in_ready stays 0 during HOLD, so no new operand can be accepted in the same cycle as a result handshake. The minimum issue interval is DIGITS+2 cycles.
- out_ready is ignored when out_valid=0.
- in_a and in_b may change freely after acceptance; only the latched copies are used.
- out_sum keeps its last value in IDLE. It is overwritten digit by digit during ADD and is only meaningful while out_valid=1.
- in_valid during ADD or HOLD is ignored; the producer must hold it until in_ready.

Test Plan:
- DIGITS=4, in_a=0x1234, in_b=0x5678, in_carry=0 -> out_valid 4 cycles after accept, out_sum=0x6912, out_carry=0, out_err=0.
- in_a=0x9999, in_b=0x0001, in_carry=0 -> out_sum=0x0000, out_carry=1. Repeat with in_a=0x9999, in_b=0x9999, in_carry=1 -> out_sum=0x9999, out_carry=1.
- Exhaustive single-digit sweep with DIGITS=1: a,b in 0..9 and in_carry in 0..1 -> 10*out_carry+out_sum == a+b+in_carry in all 200 cases, out_err=0.
- in_a=0x00A0, in_b=0x0001 -> out_err=1 with out_valid. The next operation, 0x0001+0x0001, gives out_err=0 and out_sum=0x0002.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, busy=1 throughout. Then pulse out_ready -> IDLE the next cycle, and a new accept gives the correct result.
- Assert reset during ADD, after 2 digits of 0x5555+0x5555 -> next cycle IDLE, out_valid=0, out_sum=0, out_carry=0, in_ready=1. A following 0x0005+0x0005 gives 0x0010.
